// File: rtl/serial_pair_pkg.sv
// Shared types and helpers for the MSB-first serial pair serializer.
package serial_pair_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // Bit counter width; a 1-bit operand still needs a 1-bit counter.
    function automatic int cnt_width(input int width);
        return ($clog2(width) < 1) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/msb_first_shift_reg.sv
// Parallel-load, shift-left register presenting its MSB; zeros shift in at the LSB.
module msb_first_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             msb
);

    logic [WIDTH-1:0] shreg;

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg <= '0;
        end else if (load) begin
            shreg <= din;
        end else if (shift) begin
            shreg <= shreg << 1;
        end
    end

    assign msb = shreg[WIDTH-1];

endmodule

// File: rtl/serial_pair_serializer_msb_first.sv
// Serializes an operand pair MSB first on two lines with first/last frame markers.
// Define SERIAL_PAIR_SERIALIZER_BACK_TO_BACK_EN to accept the next pair during the last bit.
module serial_pair_serializer_msb_first
    import serial_pair_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    output logic             out_first,
    output logic             out_last,
    output logic             a,
    output logic             b
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic          first_q;
    logic          last_bit;
    logic          hs;
    logic          shift_en;
    logic          msb_a;
    logic          msb_b;

    assign last_bit = (cnt == '0);

`ifdef SERIAL_PAIR_SERIALIZER_BACK_TO_BACK_EN
    assign in_ready = (state == ST_IDLE) || (state == ST_SHIFT && last_bit);
`else
    assign in_ready = (state == ST_IDLE);
`endif

    assign hs = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        out_valid = 1'b0;
        shift_en  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (hs) begin
                    state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                out_valid = 1'b1;
                shift_en  = !hs;
                // A reload during the last bit keeps the FSM in SHIFT.
                if (last_bit && !hs) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            first_q <= 1'b0;
        end else begin
            first_q <= hs;
            if (hs) begin
                cnt <= CNT_LOAD;
            end else if (state == ST_SHIFT && !last_bit) begin
                cnt <= cnt - CW'(1);
            end
        end
    end

    msb_first_shift_reg #(.WIDTH(WIDTH)) u_shreg_a (
        .clk   (clk),
        .rst   (rst),
        .load  (hs),
        .shift (shift_en),
        .din   (in_a),
        .msb   (msb_a)
    );

    msb_first_shift_reg #(.WIDTH(WIDTH)) u_shreg_b (
        .clk   (clk),
        .rst   (rst),
        .load  (hs),
        .shift (shift_en),
        .din   (in_b),
        .msb   (msb_b)
    );

    // Serial outputs are forced low whenever no bit is being presented.
    assign a         = out_valid & msb_a;
    assign b         = out_valid & msb_b;
    assign out_first = out_valid & first_q;
    assign out_last  = out_valid & last_bit;

endmodule
